// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipe_ctrl pipeline sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  // we = {pc, if_id, id_ex, ex_mem, mem_wb}, flush = {if_id, id_ex}, bubble = mem_wb NOP
  typedef struct packed {
    logic [4:0] we;
    logic [1:0] flush;
    logic       bubble;
  } stage_ctrl_t;

  localparam int DEFAULT_MEM_TIMEOUT = 255;

  localparam int WE_PC     = 4;
  localparam int WE_IF_ID  = 3;
  localparam int WE_ID_EX  = 2;
  localparam int WE_EX_MEM = 1;
  localparam int WE_MEM_WB = 0;
  localparam int FL_IF_ID  = 1;
  localparam int FL_ID_EX  = 0;

  localparam stage_ctrl_t CTRL_ADVANCE  = '{we: 5'b11111, flush: 2'b00, bubble: 1'b0};
  localparam stage_ctrl_t CTRL_FROZEN   = '{we: 5'b00000, flush: 2'b00, bubble: 1'b0};
  localparam stage_ctrl_t CTRL_HALT_REQ = '{we: 5'b00000, flush: 2'b00, bubble: 1'b1};
  localparam stage_ctrl_t CTRL_MEM_WAIT = '{we: 5'b00001, flush: 2'b00, bubble: 1'b1};
  localparam stage_ctrl_t CTRL_REDIRECT = '{we: 5'b11111, flush: 2'b11, bubble: 1'b0};
  localparam stage_ctrl_t CTRL_LOAD_USE = '{we: 5'b00111, flush: 2'b01, bubble: 1'b0};

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MEM_WAIT cycles; o_expired flags the TIMEOUT-th consecutive wait cycle.
module mem_wait_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [15:0] r_count;

  // Wait-cycle counter, cleared outside MEM_WAIT, saturating at the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 16'd0;
    end else if (i_clear) begin
      r_count <= 16'd0;
    end else if (i_enable && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  // r_count holds the number of wait cycles already completed before this one.
  assign o_expired = (r_count == 16'(TIMEOUT - 1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stalls, flushes, memory wait states and halt for the 5-stage core.
// Define PIPE_CTRL_PERF_EN to build the stall_cycles / flush_count performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_stall,
  input  logic             redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  state_e      r_state;
  state_e      w_next_state;
  logic        r_mem_err;
  logic        w_expired;
  logic        w_in_wait;
  logic        w_mem_stall;
  logic        w_timeout;
  stage_ctrl_t w_ctrl;

  assign w_in_wait = (r_state == ST_MEM_WAIT);

  mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (~w_in_wait),
    .i_enable  (w_in_wait),
    .o_expired (w_expired)
  );

  // Memory wait condition: a new unfinished access in RUN, or no completion yet in MEM_WAIT.
  always_comb begin
    w_mem_stall = 1'b0;
    case (r_state)
      ST_RUN:      w_mem_stall = dmem_req & ~dmem_ready;
      ST_MEM_WAIT: w_mem_stall = ~dmem_ready;
      default:     w_mem_stall = 1'b0;
    endcase
  end

  assign w_timeout = w_in_wait & ~halt_req & ~dmem_ready & w_expired;

  // State register and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_timeout) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  // Next-state logic; a timed-out access parks the core in HALT.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_HALT: begin
        if (resume && !r_mem_err) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_HALT;
        end
      end
      ST_RUN, ST_MEM_WAIT: begin
        if (halt_req) begin
          w_next_state = ST_HALT;
        end else if (w_timeout) begin
          w_next_state = ST_HALT;
        end else if (w_mem_stall) begin
          w_next_state = ST_MEM_WAIT;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      default: w_next_state = ST_RUN;
    endcase
  end

  // Control outputs by priority; redirect wins over load-use since the stalled op is wrong-path.
  always_comb begin
    w_ctrl = CTRL_ADVANCE;
    case (r_state)
      ST_HALT: w_ctrl = CTRL_FROZEN;
      ST_RUN, ST_MEM_WAIT: begin
        if (halt_req) begin
          w_ctrl = CTRL_HALT_REQ;
        end else if (w_mem_stall) begin
          w_ctrl = CTRL_MEM_WAIT;
        end else if (redirect) begin
          w_ctrl = CTRL_REDIRECT;
        end else if (load_use_stall) begin
          w_ctrl = CTRL_LOAD_USE;
        end else begin
          w_ctrl = CTRL_ADVANCE;
        end
      end
      default: w_ctrl = CTRL_ADVANCE;
    endcase
  end

  assign pc_we         = w_ctrl.we[WE_PC];
  assign if_id_we      = w_ctrl.we[WE_IF_ID];
  assign id_ex_we      = w_ctrl.we[WE_ID_EX];
  assign ex_mem_we     = w_ctrl.we[WE_EX_MEM];
  assign mem_wb_we     = w_ctrl.we[WE_MEM_WB];
  assign if_id_flush   = w_ctrl.flush[FL_IF_ID];
  assign id_ex_flush   = w_ctrl.flush[FL_ID_EX];
  assign mem_wb_bubble = w_ctrl.bubble;
  assign halted        = (r_state == ST_HALT);
  assign mem_err       = r_mem_err;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;
  logic             w_stall_inc;
  logic             w_flush_inc;

  // Only a redirect raises if_id_flush, so it marks an honoured redirect.
  assign w_stall_inc = ~w_ctrl.we[WE_PC] & (r_state != ST_HALT);
  assign w_flush_inc = w_ctrl.flush[FL_IF_ID];

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= {CNT_W{1'b0}};
      r_flush_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_stall_inc && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      if (w_flush_inc && (r_flush_count != {CNT_W{1'b1}})) begin
        r_flush_count <= r_flush_count + 1'b1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`else
  assign stall_cycles = {CNT_W{1'b0}};
  assign flush_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (MEM_TIMEOUT = 4); counter expectations follow PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_use_stall, redirect, dmem_req, dmem_ready, halt_req, resume;
  logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic        if_id_flush, id_ex_flush, mem_wb_bubble, halted, mem_err;
  logic [31:0] stall_cycles, flush_count;
  logic [9:0]  obs;

  int vec_cnt = 0;
  int err_cnt = 0;

  // obs = {pc, if_id, id_ex, ex_mem, mem_wb we, if_id_flush, id_ex_flush, bubble, halted, mem_err}
  localparam logic [9:0] ADV  = 10'b11111_00_0_0_0;
  localparam logic [9:0] LU   = 10'b00111_01_0_0_0;
  localparam logic [9:0] RDR  = 10'b11111_11_0_0_0;
  localparam logic [9:0] MW   = 10'b00001_00_1_0_0;
  localparam logic [9:0] HRQ  = 10'b00000_00_1_0_0;
  localparam logic [9:0] HLT  = 10'b00000_00_0_1_0;
  localparam logic [9:0] HLTE = 10'b00000_00_0_1_1;

  pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_use_stall(load_use_stall), .redirect(redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .halt_req(halt_req), .resume(resume),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
    .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_bubble(mem_wb_bubble), .halted(halted), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  assign obs = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                if_id_flush, id_ex_flush, mem_wb_bubble, halted, mem_err};

  always #5 clk = ~clk;

  function automatic logic [31:0] perf(input int n);
`ifdef PIPE_CTRL_PERF_EN
    return 32'(n);
`else
    return 32'd0;
`endif
  endfunction

  task automatic set_in(input logic lus, input logic rdr, input logic req,
                        input logic rdy, input logic hreq, input logic res);
    load_use_stall = lus; redirect = rdr; dmem_req = req;
    dmem_ready = rdy; halt_req = hreq; resume = res;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vec_cnt++; if (obs !== ADV) begin err_cnt++; $display("FAIL reset_ctrl: got %b expected %b", obs, ADV); end
    vec_cnt++; if (stall_cycles !== 32'd0) begin err_cnt++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles); end
    vec_cnt++; if (flush_count !== 32'd0) begin err_cnt++; $display("FAIL reset_flush: got %0d expected 0", flush_count); end
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    apply_reset();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vec_cnt++; if (obs !== LU) begin err_cnt++; $display("FAIL lu_stall: got %b expected %b", obs, LU); end
    next_cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vec_cnt++; if (obs !== ADV) begin err_cnt++; $display("FAIL lu_resume: got %b expected %b", obs, ADV); end
    vec_cnt++; if (stall_cycles !== perf(1)) begin err_cnt++; $display("FAIL lu_stall_cnt: got %0d expected %0d", stall_cycles, perf(1)); end
    next_cycle();
  endtask

  task automatic test_redirect_stall();
    apply_reset();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vec_cnt++; if (obs !== RDR) begin err_cnt++; $display("FAIL rdr_lus: got %b expected %b", obs, RDR); end
    next_cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vec_cnt++; if (flush_count !== perf(1)) begin err_cnt++; $display("FAIL rdr_flush_cnt: got %0d expected %0d", flush_count, perf(1)); end
    vec_cnt++; if (stall_cycles !== 32'd0) begin err_cnt++; $display("FAIL rdr_stall_cnt: got %0d expected 0", stall_cycles); end
    next_cycle();
  endtask

  task automatic test_mem_wait3();
    apply_reset();
    for (int c = 0; c < 2; c++) begin
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      vec_cnt++; if (obs !== MW) begin err_cnt++; $display("FAIL mem3_wait%0d: got %b expected %b", c, obs, MW); end
      next_cycle();
    end
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    vec_cnt++; if (obs !== RDR) begin err_cnt++; $display("FAIL mem3_advance: got %b expected %b", obs, RDR); end
    next_cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vec_cnt++; if (obs !== ADV) begin err_cnt++; $display("FAIL mem3_after: got %b expected %b", obs, ADV); end
    vec_cnt++; if (stall_cycles !== perf(2)) begin err_cnt++; $display("FAIL mem3_stall_cnt: got %0d expected %0d", stall_cycles, perf(2)); end
    vec_cnt++; if (flush_count !== perf(1)) begin err_cnt++; $display("FAIL mem3_flush_cnt: got %0d expected %0d", flush_count, perf(1)); end
    next_cycle();
  endtask

  task automatic test_timeout();
    apply_reset();
    // one RUN cycle entering the wait, then four MEM_WAIT cycles
    for (int c = 0; c < 5; c++) begin
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      vec_cnt++; if (obs !== MW) begin err_cnt++; $display("FAIL tmo_wait%0d: got %b expected %b", c, obs, MW); end
      next_cycle();
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vec_cnt++; if (obs !== HLTE) begin err_cnt++; $display("FAIL tmo_halt: got %b expected %b", obs, HLTE); end
    vec_cnt++; if (stall_cycles !== perf(5)) begin err_cnt++; $display("FAIL tmo_stall_cnt: got %0d expected %0d", stall_cycles, perf(5)); end
    next_cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    vec_cnt++; if (obs !== HLTE) begin err_cnt++; $display("FAIL tmo_resume_cycle: got %b expected %b", obs, HLTE); end
    next_cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vec_cnt++; if (obs !== HLTE) begin err_cnt++; $display("FAIL tmo_stay_halt: got %b expected %b", obs, HLTE); end
    next_cycle();
    rst_n = 1'b0;
    #2;
    vec_cnt++; if (obs !== ADV) begin err_cnt++; $display("FAIL tmo_reset_ctrl: got %b expected %b", obs, ADV); end
    vec_cnt++; if (stall_cycles !== 32'd0) begin err_cnt++; $display("FAIL tmo_reset_stall: got %0d expected 0", stall_cycles); end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_halt();
    apply_reset();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    vec_cnt++; if (obs !== HRQ) begin err_cnt++; $display("FAIL halt_req: got %b expected %b", obs, HRQ); end
    next_cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vec_cnt++; if (obs !== HLT) begin err_cnt++; $display("FAIL halt_frozen%0d: got %b expected %b", c, obs, HLT); end
      next_cycle();
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    vec_cnt++; if (obs !== HLT) begin err_cnt++; $display("FAIL halt_resume_cycle: got %b expected %b", obs, HLT); end
    next_cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vec_cnt++; if (obs !== ADV) begin err_cnt++; $display("FAIL halt_resumed: got %b expected %b", obs, ADV); end
    vec_cnt++; if (stall_cycles !== perf(1)) begin err_cnt++; $display("FAIL halt_stall_cnt: got %0d expected %0d", stall_cycles, perf(1)); end
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    for (int c = 0; c < 2; c++) begin
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      next_cycle();
    end
    @(negedge clk);
    vec_cnt++; if (stall_cycles !== perf(2)) begin err_cnt++; $display("FAIL midw_stall_pre: got %0d expected %0d", stall_cycles, perf(2)); end
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    vec_cnt++; if (obs !== ADV) begin err_cnt++; $display("FAIL midw_reset_ctrl: got %b expected %b", obs, ADV); end
    vec_cnt++; if (stall_cycles !== 32'd0) begin err_cnt++; $display("FAIL midw_reset_stall: got %0d expected 0", stall_cycles); end
    next_cycle();
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    vec_cnt++; if (obs !== ADV) begin err_cnt++; $display("FAIL midw_req_ready: got %b expected %b", obs, ADV); end
    next_cycle();
  endtask

  initial begin
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_load_use();
    test_redirect_stall();
    test_mem_wait3();
    test_timeout();
    test_halt();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
